// File: rtl/ai_core_pkg.sv
// Shared definitions for the neuron core: FSM states, activation codes and
// the saturating clamp used on the bias-add result.
package ai_core_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_BIAS   = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    localparam int unsigned ACT_NONE = 0;
    localparam int unsigned ACT_RELU = 1;

    // Widest intermediate the clamp accepts; callers sign-extend into it.
    localparam int unsigned CLAMP_W = 128;

    // Clamp a signed value to the signed range of 'width' bits; 'clipped' flags saturation.
    function automatic logic signed [CLAMP_W-1:0] clamp_signed(
        input  logic signed [CLAMP_W-1:0] value,
        input  int unsigned               width,
        output logic                      clipped
    );
        logic signed [CLAMP_W-1:0] hi;
        logic signed [CLAMP_W-1:0] lo;
        logic signed [CLAMP_W-1:0] res;
        hi      = $signed((CLAMP_W'(1) << (width - 1)) - CLAMP_W'(1));
        lo      = ~hi;
        res     = value;
        clipped = 1'b0;
        if (value > hi) begin
            res     = hi;
            clipped = 1'b1;
        end else if (value < lo) begin
            res     = lo;
            clipped = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/ai_mac_stage.sv
// Combinational signed fixed-point multiply with arithmetic rescale by FRACT_BITS.
module ai_mac_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FRACT_BITS = 16
) (
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [DATA_WIDTH-1:0]   weight,
    output logic [2*DATA_WIDTH-1:0] product
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;

    logic signed [PROD_W-1:0] data_ext;
    logic signed [PROD_W-1:0] weight_ext;
    logic signed [PROD_W-1:0] full;

    always_comb begin
        data_ext   = {{DATA_WIDTH{data[DATA_WIDTH-1]}}, data};
        weight_ext = {{DATA_WIDTH{weight[DATA_WIDTH-1]}}, weight};
        full       = data_ext * weight_ext;
        product    = full >>> FRACT_BITS;
    end

endmodule

// File: rtl/ai_neuron_core.sv
// Single neuron: streams an input vector through a weighted accumulate, adds a
// bias with saturation, applies the activation and hands the result downstream.
module ai_neuron_core
    import ai_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FRACT_BITS = 16,
    parameter int unsigned NUM_INPUTS = 8,
    parameter int unsigned ACT_MODE   = ACT_RELU
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wr_en,
    input  logic [$clog2(NUM_INPUTS+1)-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    output logic                              wr_err,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              sat
);

    localparam int unsigned ADDR_W = $clog2(NUM_INPUTS + 1);
    localparam int unsigned IDX_W  = $clog2(NUM_INPUTS);
    localparam int unsigned ACC_W  = 2 * DATA_WIDTH;

    state_t                    state;
    state_t                    state_next;
    logic [IDX_W-1:0]          idx;
    logic signed [ACC_W-1:0]   acc;
    logic [DATA_WIDTH-1:0]     weight_mem [NUM_INPUTS];
    logic [DATA_WIDTH-1:0]     bias;
    logic signed [ACC_W-1:0]   product;
    logic                      beat;
    logic                      vec_end;
    logic                      wr_ok;
    logic signed [CLAMP_W-1:0] sum;
    logic [DATA_WIDTH-1:0]     clamped;
    logic [DATA_WIDTH-1:0]     activated;
    logic                      clipped;

    assign in_ready = (state == ST_ACCUM);
    assign beat     = in_valid && in_ready;
    assign vec_end  = beat && (in_last || (idx == IDX_W'(NUM_INPUTS - 1)));
    // Parameters may only change while no vector is in flight.
    assign wr_ok    = wr_en && (state == ST_ACCUM) && (idx == '0)
                      && (wr_addr <= ADDR_W'(NUM_INPUTS));

    ai_mac_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRACT_BITS (FRACT_BITS)
    ) u_mac (
        .data    (in_data),
        .weight  (weight_mem[idx]),
        .product (product)
    );

    // Bias add, saturation and activation, consumed in BIAS.
    always_comb begin
        sum       = {{(CLAMP_W - ACC_W){acc[ACC_W-1]}}, acc}
                  + {{(CLAMP_W - DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
        clipped   = 1'b0;
        clamped   = DATA_WIDTH'(clamp_signed(sum, DATA_WIDTH, clipped));
        activated = clamped;
        if ((ACT_MODE == ACT_RELU) && clamped[DATA_WIDTH-1]) begin
            activated = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_ACCUM:  if (vec_end) state_next = ST_BIAS;
            ST_BIAS:   state_next = ST_OUTPUT;
            ST_OUTPUT: if (out_ready) state_next = ST_ACCUM;
            default:   state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            acc       <= '0;
            bias      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sat       <= 1'b0;
            wr_err    <= 1'b0;
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                weight_mem[i] <= '0;
            end
        end else begin
            wr_err <= wr_en && !wr_ok;
            if (wr_ok) begin
                if (wr_addr == ADDR_W'(NUM_INPUTS)) begin
                    bias <= wr_data;
                end else begin
                    weight_mem[IDX_W'(wr_addr)] <= wr_data;
                end
            end
            if (beat) begin
                acc <= acc + product;
                idx <= vec_end ? '0 : idx + IDX_W'(1);
            end
            if (state == ST_BIAS) begin
                out_valid <= 1'b1;
                out_data  <= activated;
                sat       <= clipped;
            end
            if ((state == ST_OUTPUT) && out_ready) begin
                out_valid <= 1'b0;
                acc       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ai_neuron_core.sv
// Bench for ai_neuron_core (Q16.16, 4 inputs): directed cases plus randomized
// vectors against an arithmetic reference model; ReLU and identity instances run in lockstep.
module tb_ai_neuron_core;

    localparam int unsigned DW = 32;
    localparam int unsigned FB = 16;
    localparam int unsigned NI = 4;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_err, wr_err_id;
    logic          in_valid, in_last;
    logic          in_ready, in_ready_id;
    logic [DW-1:0] in_data;
    logic          out_valid, out_valid_id;
    logic          out_ready;
    logic [DW-1:0] out_data, out_data_id;
    logic          sat, sat_id;

    always #5 clk = ~clk;

    ai_neuron_core #(.DATA_WIDTH(DW), .FRACT_BITS(FB), .NUM_INPUTS(NI), .ACT_MODE(1)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .sat(sat)
    );

    ai_neuron_core #(.DATA_WIDTH(DW), .FRACT_BITS(FB), .NUM_INPUTS(NI), .ACT_MODE(0)) dut_id (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err_id), .in_valid(in_valid), .in_ready(in_ready_id), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid_id), .out_ready(out_ready),
        .out_data(out_data_id), .sat(sat_id)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          w_m [NI];
    int          b_m;
    int          xs [NI];
    logic [31:0] wf_data;
    logic [31:0] last_out, last_out_id;
    logic        last_sat;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: sum of rescaled products plus bias, clamped to 32 bits, then activation.
    function automatic logic [31:0] model_out(input int len, input bit relu, output bit clip);
        longint acc = 0;
        longint s;
        for (int i = 0; i < len; i++) begin
            acc += (longint'(xs[i]) * longint'(w_m[i])) >>> FB;
        end
        s    = acc + longint'(b_m);
        clip = 1'b0;
        if (s > longint'(2147483647)) begin
            s    = 2147483647;
            clip = 1'b1;
        end else if (s < -longint'(2147483647) - 1) begin
            s    = -longint'(2147483647) - 1;
            clip = 1'b1;
        end
        if (relu && s < 0) s = 0;
        return 32'(s);
    endfunction

    function automatic logic [31:0] rand_val();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = 32'($urandom_range(0, 32'h80000)) - 32'h40000;
            2:       v = ($urandom_range(0, 1) == 1) ? 32'h7FFF0000 : 32'h80000000;
            default: v = 32'($urandom_range(0, 32'h1FFFF)) - 32'h10000;
        endcase
        return v;
    endfunction

    task automatic apply_reset();
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; wr_en = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < NI; i++) w_m[i] = 0;
        b_m = 0;
        check_eq("ready_after_reset", in_ready, 1);
    endtask

    task automatic write_param(input logic [AW-1:0] a, input logic [31:0] d, input bit exp_err);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check_eq("wr_err", wr_err, 32'(exp_err));
        if (!exp_err) begin
            if (a == AW'(NI)) b_m = d;
            else w_m[a] = d;
        end
    endtask

    task automatic run_vector(input int len, input bit last4, input int hold,
                              input bit wr_first, input bit wr_mid);
        logic [31:0] exp_r, exp_i;
        bit          clip_r, clip_i;
        exp_r = model_out(len, 1'b1, clip_r);
        exp_i = model_out(len, 1'b0, clip_i);
        for (int i = 0; i < len; i++) begin
            in_valid = 1'b1;
            in_data  = xs[i];
            in_last  = (i == len - 1) && (len < NI || last4);
            if (i == 0 && wr_first) begin
                wr_en = 1'b1; wr_addr = '0; wr_data = wf_data;
            end
            check_eq("in_ready_beat", in_ready, 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (i == 0 && wr_first) begin
                wr_en = 1'b0;
                check_eq("wr_err_first_beat", wr_err, 0);
                w_m[0] = wf_data;
            end
            if (i == 0 && wr_mid && len > 1) begin
                wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'h12345678;
                @(posedge clk);
                #1;
                wr_en = 1'b0;
                check_eq("wr_err_busy", wr_err, 1);
            end
        end
        check_eq("valid_t1", out_valid, 0);
        check_eq("ready_t1", in_ready, 0);
        @(posedge clk);
        #1;
        check_eq("valid_t2", out_valid, 1);
        check_eq("data_relu", out_data, exp_r);
        check_eq("sat_relu", sat, 32'(clip_r));
        check_eq("data_ident", out_data_id, exp_i);
        check_eq("sat_ident", sat_id, 32'(clip_i));
        last_out    = out_data;
        last_out_id = out_data_id;
        last_sat    = sat;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_data", out_data, exp_r);
            check_eq("hold_sat", sat, 32'(clip_r));
            check_eq("hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("valid_after_take", out_valid, 0);
        check_eq("ready_after_take", in_ready, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0; wf_data = '0;
        apply_reset();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_sat", sat, 0);
        check_eq("rst_wr_err", wr_err, 0);

        // Weights 0.5, bias ~0.1, inputs 1..4
        for (int i = 0; i < NI; i++) write_param(AW'(i), 32'h00008000, 1'b0);
        write_param(3'd4, 32'h0000199A, 1'b0);
        for (int i = 0; i < NI; i++) xs[i] = (i + 1) << 16;
        run_vector(4, 1'b1, 0, 1'b0, 1'b0);
        check_eq("half_weights", last_out, 32'h0005199A);
        check_eq("half_sat", 32'(last_sat), 0);

        // Weights -1.0: ReLU clips, identity passes the negative sum
        for (int i = 0; i < NI; i++) write_param(AW'(i), 32'hFFFF0000, 1'b0);
        run_vector(4, 1'b1, 1, 1'b0, 1'b0);
        check_eq("neg_relu", last_out, 32'h00000000);
        check_eq("neg_ident", last_out_id, 32'hFFF6199A);
        check_eq("neg_sat", 32'(last_sat), 0);

        // Positive saturation
        for (int i = 0; i < NI; i++) write_param(AW'(i), 32'h7FFF0000, 1'b0);
        write_param(3'd4, 32'h0, 1'b0);
        for (int i = 0; i < NI; i++) xs[i] = 32'h7FFF0000;
        run_vector(4, 1'b1, 0, 1'b0, 1'b0);
        check_eq("sat_data", last_out, 32'h7FFFFFFF);
        check_eq("sat_flag", 32'(last_sat), 1);

        // Short vector with a held output
        for (int i = 0; i < NI; i++) write_param(AW'(i), 32'h00008000, 1'b0);
        xs[0] = 32'h00010000; xs[1] = 32'h00020000;
        run_vector(2, 1'b1, 5, 1'b0, 1'b0);
        check_eq("short_data", last_out, 32'h00018000);

        // Rejected writes: mid-vector and out-of-range addresses
        for (int i = 0; i < NI; i++) xs[i] = (i + 1) << 16;
        run_vector(4, 1'b0, 0, 1'b0, 1'b1);
        check_eq("busy_wr_no_effect", last_out, 32'h00050000);
        write_param(3'd5, 32'hDEADBEEF, 1'b1);
        write_param(3'd7, 32'hDEADBEEF, 1'b1);

        // Write alongside the first beat uses the old weight
        wf_data = 32'h00030000;
        run_vector(4, 1'b1, 0, 1'b1, 1'b0);
        check_eq("same_cycle_old_w", last_out, 32'h00050000);
        run_vector(4, 1'b1, 0, 1'b0, 1'b0);
        check_eq("same_cycle_new_w", last_out, 32'h00078000);

        // Reset mid-vector discards it and clears parameters
        in_valid = 1'b1; in_data = 32'h00010000;
        repeat (2) @(posedge clk);
        #1;
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check_eq("no_valid_after_reset", out_valid, 0);
        end
        for (int i = 0; i < NI; i++) xs[i] = rand_val();
        run_vector(4, 1'b1, 0, 1'b0, 1'b0);
        check_eq("zero_after_reset", last_out_id, 32'h0);

        // Randomized vectors
        for (int it = 0; it < 60; it++) begin
            int nw;
            nw = $urandom_range(0, 4);
            for (int k = 0; k < nw; k++) begin
                logic [AW-1:0] a;
                a = AW'($urandom_range(0, 7));
                write_param(a, rand_val(), a > AW'(NI));
            end
            for (int i = 0; i < NI; i++) xs[i] = rand_val();
            wf_data = rand_val();
            run_vector($urandom_range(1, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                       $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ai_neuron_core.md
AI_NEURON_CORE -- requirements
Module: ai_neuron_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: signed fixed-point data/weight/bias width.
REQ-002 SHALL have parameter FRACT_BITS, default 16: fractional bits of all fixed-point values.
REQ-003 SHALL have parameter NUM_INPUTS, default 8: vector length and weight-memory depth, at least 2.
REQ-004 SHALL have parameter ACT_MODE, default 1: 0 = identity, 1 = ReLU.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 SHALL have ports wr_en (input, 1 bit), wr_addr (input, $clog2(NUM_INPUTS+1) bits) and wr_data (input, DATA_WIDTH bits): parameter write port; addresses 0..NUM_INPUTS-1 select weights, address NUM_INPUTS selects the bias.
REQ-008 SHALL have port wr_err, output, 1 bit: one-cycle pulse when a write is rejected.
REQ-009 SHALL have ports in_valid (input, 1 bit), in_ready (output, 1 bit), in_data (input, DATA_WIDTH bits) and in_last (input, 1 bit): input element stream.
REQ-010 SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit) and out_data (output, DATA_WIDTH bits): result stream.
REQ-011 SHALL have port sat, output, 1 bit: the current out_data was saturated; it is valid while out_valid=1.

Function
REQ-012 SHALL implement states ACCUM, BIAS and OUTPUT.
REQ-013 SHALL accept an input beat only when in_valid and in_ready are both 1; in_ready SHALL be 1 exactly when the state is ACCUM.
REQ-014 On each accepted beat: product = signed in_data * signed weight[idx], computed at 2*DATA_WIDTH bits; product SHALL be arithmetic-shifted right by FRACT_BITS and added to a 2*DATA_WIDTH-bit accumulator; idx SHALL then increment.
REQ-015 A beat with in_last=1, or with idx = NUM_INPUTS-1, SHALL end the vector: next state BIAS, idx cleared. Unused weights are ignored.
REQ-016 BIAS (one cycle) SHALL add the sign-extended bias to the accumulator and clamp the sum to the signed DATA_WIDTH range. It SHALL then apply the activation (ReLU maps negative values to 0) and register the result into out_data and sat. Next state OUTPUT.
REQ-017 Latency: if the last beat is accepted in cycle T, out_valid SHALL be 1 in cycle T+2.
REQ-018 In OUTPUT, out_valid, out_data and sat SHALL hold stable until out_ready=1.
REQ-019 On an OUTPUT cycle with out_ready=1, the next cycle SHALL return to ACCUM with out_valid=0, the accumulator at 0 and idx at 0.
REQ-020 A write SHALL be accepted only in ACCUM with idx=0 (no vector in flight). Otherwise, and for any wr_addr > NUM_INPUTS, the write SHALL be dropped and wr_err SHALL pulse the next cycle.
REQ-021 A write and an accepted first beat in the same cycle SHALL both take effect; the beat SHALL use the old weight.
REQ-022 sat SHALL reflect only the bias-add clamp; ReLU zeroing does not set sat.

Reset
REQ-023 On reset SHALL set state=ACCUM, idx=0, accumulator=0, all weights and bias=0, out_valid=0, out_data=0, sat=0 and wr_err=0.
REQ-024 Reset during a vector or in OUTPUT SHALL discard it; the next cycle after reset deasserts SHALL have in_ready=1.

Structure
REQ-025 The state enum, the ACT_NONE/ACT_RELU constants and the saturating-clamp function SHALL live in shared package ai_core_pkg.
REQ-026 The multiply-and-shift datapath SHALL be a sub-module, ai_mac_stage, with combinational output and parameters DATA_WIDTH and FRACT_BITS.

Verification (NUM_INPUTS=4, Q16.16)
REQ-027 Weights all 0x00008000 (0.5), bias 0x0000199A; inputs 0x00010000, 0x00020000, 0x00030000, 0x00040000 with in_last on the 4th -> out_data 0x0005199A, sat=0, out_valid 2 cycles after the last beat.
REQ-028 Weights all 0xFFFF0000 (-1.0), same inputs, ACT_MODE=1 -> out_data 0x00000000, sat=0; ACT_MODE=0 -> out_data 0xFFF6199A.
REQ-029 Weights and inputs all 0x7FFF0000, bias 0 -> out_data 0x7FFFFFFF, sat=1.
REQ-030 Weights 0.5, in_last on the 2nd beat (1.0, 2.0), bias 0 -> out_data 0x00018000; out_ready held 0 for 5 cycles -> out_valid/out_data stable and in_ready=0 throughout.
REQ-031 Write issued after the 1st beat -> wr_err pulses, weights unchanged. Write to address 5 -> wr_err pulses.
REQ-032 Reset asserted after 2 beats -> out_valid never asserts for that vector; a fresh 4-beat vector after reset yields 0 (weights reset to 0).
